// File: rtl/program_loader.sv
// program_loader: streams a fixed-length program image from a host
// valid/ready interface into a RAM write port, holding the CPU in reset
// until the image is complete.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, one extra
// checksum byte is accepted after the image; the image is accepted only if
// the sum of all image bytes plus the checksum byte is zero modulo
// 2^DATA_WIDTH. Otherwise checksum_err is raised and the CPU stays in reset.
//
// Parameters:
//   DATA_WIDTH  RAM word width
//   ADDR_WIDTH  RAM address width
//   LOAD_LEN    bytes per image (1 .. 2^ADDR_WIDTH)
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           single-cycle load request (honoured in IDLE/DONE only)
//   in_data/in_valid/in_ready  host byte stream handshake
//   ram_we/ram_addr/ram_wdata  registered RAM write port (1-cycle latency)
//   cpu_reset       CPU held in reset while high
//   busy            load in progress
//   done            image loaded, CPU released
//   checksum_err    sticky checksum failure (0 without the macro)
module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LOAD_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  checksum_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LOAD_LEN - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  load_xfer;
  logic                  last_byte;
  logic                  start_ok;

  assign load_xfer = (state == LOAD) && in_valid;
  assign last_byte = (cnt == LAST);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_total;
  logic                  check_xfer;
  logic                  err;

  assign check_xfer   = (state == CHECK) && in_valid;
  assign sum_total    = sum + in_data;
  assign checksum_err = err;
`else
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_reset  = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (load_xfer && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (check_xfer) state_next = (sum_total == '0) ? DONE : IDLE;
      end
`endif
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write port is registered: a transfer on this edge shows up as a
  // one-cycle ram_we pulse carrying the pre-increment address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if (start_ok) cnt <= '0;
      if (load_xfer) begin
        ram_we    <= 1'b1;
        ram_addr  <= cnt;
        ram_wdata <= in_data;
        cnt       <= last_byte ? '0 : cnt + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (start_ok) begin
        sum <= '0;
        err <= 1'b0;
      end else begin
        if (load_xfer) sum <= sum_total;
        if (check_xfer && (sum_total != '0)) err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (default parameters).
// Reference model: image byte i is expected at RAM address i, written one
// cycle after it is accepted; a behavioural RAM array holds expected
// contents and is compared against a RAM fed by the DUT write port.
module tb_program_loader;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int LEN = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          checksum_err;

  program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .checksum_err(checksum_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // RAM behind the DUT write port, plus a write counter
  logic [DW-1:0] tb_ram [LEN];
  int            wr_count = 0;
  always @(posedge clk) begin
    if (ram_we) begin
      tb_ram[ram_addr] <= ram_wdata;
      wr_count <= wr_count + 1;
    end
  end

  // Expected RAM contents and stream bookkeeping
  logic [DW-1:0] model_ram [LEN];
  logic [DW-1:0] image [LEN];
  int            k;       // next expected address
  int            ld_sum;  // running sum of accepted image bytes

  // status = {in_ready, busy, done, cpu_reset}
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_LOAD = 4'b1101;
  localparam logic [3:0] ST_DONE = 4'b0010;

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; ld_sum = 0;
    vectors++;
    if ({in_ready, busy, done, cpu_reset, ram_we, checksum_err} !== {ST_LOAD, 2'b00}) begin
      miscompares++;
      $display("FAIL start_enter_load: got %b expected %b",
               {in_ready, busy, done, cpu_reset, ram_we, checksum_err}, {ST_LOAD, 2'b00});
    end
  endtask

  // gap_mode: 0 = valid always, 1 = valid every other cycle, 2 = random
  // data_mode: 0 = random, 1 = image, 2 = all 0x01
  task automatic stream(input int n, input int gap_mode, input int data_mode);
    int sent = 0;
    int cyc = 0;
    bit v;
    logic [DW-1:0] d;
    logic [AW-1:0] ka;
    while (sent < n && cyc < 400) begin
      @(negedge clk);
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d = (data_mode == 1) ? image[k] : (data_mode == 2) ? 8'h01 : 8'($urandom);
      in_valid = v; in_data = d;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL in_ready_load: got %b expected 1 (byte %0d)", in_ready, k);
      end
      @(posedge clk); #1;
      ka = k[AW-1:0];
      vectors++;
      if (v) begin
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ka, d}) begin
          miscompares++;
          $display("FAIL write_port: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                   ram_we, ram_addr, ram_wdata, ka, d);
        end
        model_ram[k] = d;
        ld_sum += int'(d);
        k = (k + 1) % LEN;
        sent++;
      end else if (ram_we !== 1'b0) begin
        miscompares++;
        $display("FAIL no_write_on_stall: got ram_we=%b expected 0", ram_we);
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (sent < n) begin
      miscompares++;
      $display("FAIL stream_timeout: got %0d bytes expected %0d", sent, n);
    end
  endtask

  // Completes a load whose LEN bytes have been streamed, checks DONE.
  task automatic finish_load(input string name);
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] ck;
    ck = 8'(-ld_sum);
    @(negedge clk);
    in_valid = 1'b1; in_data = ck;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_checksum_nowrite: got ram_we=%b expected 0", name, ram_we);
    end
`endif
    vectors++;
    if ({in_ready, busy, done, cpu_reset, checksum_err} !== {ST_DONE, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_done_state: got %b expected %b", name,
               {in_ready, busy, done, cpu_reset, checksum_err}, {ST_DONE, 1'b0});
    end
  endtask

  task automatic check_ram(input string name, input int base, input int writes);
    int bad = 0;
    @(posedge clk); #1;
    for (int i = 0; i < LEN; i++) if (tb_ram[i] !== model_ram[i]) bad++;
    vectors++;
    if (bad != 0 || (wr_count - base) != writes) begin
      miscompares++;
      $display("FAIL %s_ram: got %0d bad words, %0d writes expected 0 bad words, %0d writes",
               name, bad, wr_count - base, writes);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ram_we, ram_addr, ram_wdata, in_ready, busy, done, checksum_err, cpu_reset} !==
        {1'b0, 4'h0, 8'h00, 4'b0001}) begin
      miscompares++;
      $display("FAIL reset_values: got we=%b addr=%h data=%h rdy/busy/done/err/cpu=%b expected 0 0 00 0001",
               ram_we, ram_addr, ram_wdata, {in_ready, busy, done, checksum_err, cpu_reset});
    end
    @(negedge clk); reset = 1'b0;
    // in_valid in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
      vectors++;
      if ({ram_we, in_ready, busy, done, cpu_reset} !== {1'b0, ST_IDLE}) begin
        miscompares++;
        $display("FAIL idle_ignore: got %b expected %b",
                 {ram_we, in_ready, busy, done, cpu_reset}, {1'b0, ST_IDLE});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int base = wr_count;
    do_start();
    stream(LEN, 0, 1);
    finish_load("full_load");
    check_ram("full_load", base, LEN);
  endtask

  task automatic test_done_ignore();
    int base = wr_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'hAA;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL done_in_ready: got %b expected 0", in_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if ({ram_we, in_ready, busy, done, cpu_reset} !== {1'b0, ST_DONE}) begin
        miscompares++;
        $display("FAIL done_ignore: got %b expected %b",
                 {ram_we, in_ready, busy, done, cpu_reset}, {1'b0, ST_DONE});
      end
    end
    in_valid = 1'b0;
    check_ram("done_ignore", base, 0);
  endtask

  task automatic test_gapped_load();
    int base = wr_count;
    do_start();
    stream(LEN, 1, 1);
    finish_load("gapped");
    check_ram("gapped", base, LEN);
  endtask

  task automatic test_start_ignored();
    int base = wr_count;
    do_start();
    stream(3, 0, 0);
    start = 1'b1;
    stream(1, 0, 0);
    start = 1'b0;
    stream(LEN - 4, 2, 0);
    finish_load("start_ignored");
    check_ram("start_ignored", base, LEN);
  endtask

  task automatic test_reset_midload();
    int base = wr_count;
    do_start();
    stream(4, 0, 0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (ram_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_write: got ram_we=%b expected 1", ram_we);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ram_we, in_ready, busy, done, cpu_reset} !== {1'b0, ST_IDLE}) begin
      miscompares++;
      $display("FAIL reset_abort: got %b expected %b",
               {ram_we, in_ready, busy, done, cpu_reset}, {1'b0, ST_IDLE});
    end
    @(negedge clk); reset = 1'b0;
    // addresses 0..3 keep new bytes; the suppressed write leaves address 4 as before
    check_ram("reset_midload", base, 4);
    base = wr_count;
    do_start();
    stream(LEN, 0, 0);
    finish_load("reload");
    check_ram("reload", base, LEN);
  endtask

  task automatic test_back_to_back();
    int base = wr_count;
    do_start();
    stream(LEN, 2, 0);
    finish_load("b2b");
    check_ram("b2b", base, LEN);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] cks [2];
    cks[0] = 8'hF0; cks[1] = 8'hF1;
    for (int t = 0; t < 2; t++) begin
      do_start();
      stream(LEN, 0, 2);
      @(negedge clk); in_valid = 1'b1; in_data = cks[t];
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (t == 0 && {in_ready, busy, done, cpu_reset, checksum_err} !== {ST_DONE, 1'b0}) begin
        miscompares++;
        $display("FAIL checksum_good: got %b expected %b",
                 {in_ready, busy, done, cpu_reset, checksum_err}, {ST_DONE, 1'b0});
      end
      if (t == 1 && {in_ready, busy, done, cpu_reset, checksum_err} !== {ST_IDLE, 1'b1}) begin
        miscompares++;
        $display("FAIL checksum_bad: got %b expected %b",
                 {in_ready, busy, done, cpu_reset, checksum_err}, {ST_IDLE, 1'b1});
      end
    end
    do_start();
    stream(LEN, 0, 0);
    finish_load("after_bad_checksum");
  endtask
`endif

  initial begin
    // LDI A,0x08 ; HALT followed by padding
    image[0] = 8'h3E; image[1] = 8'h08; image[2] = 8'h76;
    for (int i = 3; i < LEN; i++) image[i] = 8'h00;
    k = 0; ld_sum = 0;
    test_reset();
    test_full_load();
    test_done_ignore();
    test_gapped_load();
    test_start_ignored();
    test_reset_midload();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, RAM address width in bits.
REQ-003 Parameter LOAD_LEN, default 16, bytes per image; SHALL satisfy 1 <= LOAD_LEN <= 2^ADDR_WIDTH.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 in_data  input  DATA_WIDTH  image byte from host stream.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 ram_we  output  1  RAM write strobe, one cycle per byte.
REQ-011 ram_addr  output  ADDR_WIDTH  RAM write address.
REQ-012 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-013 cpu_reset  output  1  holds CPU in reset while high.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  image loaded; CPU released.
REQ-016 checksum_err  output  1  sticky image checksum failure.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CHECK (macro only), DONE.
REQ-018 IDLE: in_ready=0, cpu_reset=1, busy=0, done=0; start=1 -> LOAD, byte counter=0, checksum_err cleared.
REQ-019 LOAD: in_ready=1, busy=1, cpu_reset=1; transfer occurs only when in_valid && in_ready on a rising edge.
REQ-020 Each transfer SHALL produce ram_we=1 for exactly the following cycle, with ram_addr=counter value at transfer and ram_wdata=transferred byte (latency 1, registered outputs).
REQ-021 Counter SHALL increment per transfer; addresses written are 0..LOAD_LEN-1 in order, no gaps, no repeats.
REQ-022 On the LOAD_LEN-th transfer, counter SHALL wrap to 0 and FSM SHALL go to DONE (or CHECK with macro) on the same edge; in_ready SHALL drop the next cycle.
REQ-023 in_valid low SHALL stall LOAD indefinitely with no write and no counter change.
REQ-024 DONE: cpu_reset=0, done=1, busy=0, in_ready=0; start=1 -> LOAD (re-load, cpu_reset reasserted next cycle).
REQ-025 start while in LOAD or CHECK SHALL be ignored.
REQ-026 in_valid outside LOAD/CHECK SHALL be ignored; no RAM write.
REQ-027 ram_we SHALL be 0 whenever no transfer occurred in the previous cycle.

Reset
REQ-028 reset high SHALL immediately force IDLE, counter=0, ram_we=0, ram_addr=0, ram_wdata=0, in_ready=0, busy=0, done=0, checksum_err=0, cpu_reset=1.
REQ-029 reset mid-load SHALL abort; a pending ram_we SHALL be suppressed; RAM contents already written are not cleared.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: after LOAD_LEN data bytes FSM enters CHECK, accepts one extra checksum byte (in_ready=1, no RAM write).
REQ-031 With LOADER_CHECKSUM_EN: if (sum of LOAD_LEN bytes + checksum byte) mod 2^DATA_WIDTH == 0 -> DONE; else checksum_err=1, -> IDLE with cpu_reset=1; checksum_err held until next start or reset.
REQ-032 Without LOADER_CHECKSUM_EN: no CHECK state, LOAD -> DONE directly, checksum_err tied 0.

Verification
REQ-033 Reset, start, stream 16 bytes of the LDI-to-A test image with in_valid always high -> 16 writes at addr 0x0..0xF in consecutive cycles, done=1, cpu_reset=0; CPU runs to halt with A=0x08.
REQ-034 Same image with in_valid low every other cycle -> identical RAM contents, 16 ram_we pulses, no write during gaps, done after last byte.
REQ-035 Pulse start after byte 3 of a load -> ignored; counter continues, writes at 0x3.. unchanged, exactly 16 writes total.
REQ-036 Assert reset after byte 5 accepted (ram_we pending) -> ram_we=0 that cycle, IDLE, cpu_reset=1, done=0; RAM 0x0..0x4 retain values; new start reloads from 0x0.
REQ-037 LOADER_CHECKSUM_EN: 16 bytes all 0x01 plus checksum 0xF0 -> DONE; same with checksum 0xF1 -> checksum_err=1, IDLE, cpu_reset=1.
REQ-038 Without macro, in DONE drive in_valid=1 with 0xAA for 4 cycles -> in_ready=0, no ram_we, RAM unchanged.
